router_nport: RTL and testbench

- Parametrised successor to the 3-port packet router: one input packet stream is steered to NPORTS output FIFOs.
- Routing uses the address field in the header byte.
- Adds a configurable data width, FIFO depth and port count, an invalid-address drop path, a payload-length check, and a per-port read timeout that soft-flushes a stalled FIFO.

---
 rtl/router_nport.sv | 191 +++++++++++++++++++
 tb/tb_router_nport.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/router_nport.sv
// Packet router: steers one header/payload/parity stream into NPORTS output FIFOs,
// with invalid-address drop, parity/length checking and per-port read-timeout flush.
module router_nport #(
    parameter int DW      = 8,
    parameter int NPORTS  = 4,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [DW-1:0]        data_in,
    input  logic [NPORTS-1:0]    read_enb,
    output logic [NPORTS*DW-1:0] data_out,
    output logic [NPORTS-1:0]    vld_out,
    output logic                 busy,
    output logic                 error,
    output logic                 drop,
    output logic [NPORTS-1:0]    soft_rst
);

    localparam int AW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int LW = DW - AW;
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {DECODE, LOAD_DATA, CHECK, DROP} state_t;

    state_t            state, next_state;
    logic [AW-1:0]     addr_q;
    logic [LW-1:0]     len_q;
    logic [LW-1:0]     count_q;
    logic [DW-1:0]     parity_q;
    logic              err_pending;
    logic [NPORTS-1:0] full;
    logic [NPORTS-1:0] wr_en;
    logic [AW-1:0]     hdr_addr;
    logic              hdr_ok;
    logic              hdr_accept;
    logic              pay_accept;
    logic              par_accept;
    logic              drop_set;

    assign hdr_addr = data_in[AW-1:0];
    assign hdr_ok   = (int'(hdr_addr) < NPORTS);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= DECODE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        wr_en      = '0;
        hdr_accept = 1'b0;
        pay_accept = 1'b0;
        par_accept = 1'b0;
        drop_set   = 1'b0;
        case (state)
            DECODE: begin
                busy = pkt_valid & hdr_ok & full[hdr_addr];
                if (pkt_valid && !busy) begin
                    if (hdr_ok) begin
                        wr_en[hdr_addr] = 1'b1;
                        hdr_accept      = 1'b1;
                        next_state      = LOAD_DATA;
                    end else begin
                        drop_set   = 1'b1;
                        next_state = DROP;
                    end
                end
            end
            LOAD_DATA: begin
                busy = full[addr_q];
                if (!busy) begin
                    wr_en[addr_q] = 1'b1;
                    if (pkt_valid) begin
                        pay_accept = 1'b1;
                    end else begin
                        par_accept = 1'b1;
                        next_state = CHECK;
                    end
                end
            end
            CHECK: begin
                busy       = 1'b1;
                next_state = DECODE;
            end
            DROP: begin
                if (!pkt_valid)
                    next_state = DECODE;
            end
            default: next_state = DECODE;
        endcase
    end

    // The verdict is formed when the parity byte arrives and published on leaving CHECK.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q      <= '0;
            len_q       <= '0;
            count_q     <= '0;
            parity_q    <= '0;
            err_pending <= 1'b0;
            error       <= 1'b0;
            drop        <= 1'b0;
        end else begin
            drop <= drop_set;
            if (hdr_accept) begin
                addr_q   <= hdr_addr;
                len_q    <= data_in[DW-1:AW];
                parity_q <= data_in;
                count_q  <= '0;
                error    <= 1'b0;
            end
            if (pay_accept) begin
                parity_q <= parity_q ^ data_in;
                if (count_q != '1)
                    count_q <= count_q + 1'b1;
            end
            if (par_accept)
                err_pending <= (parity_q != data_in) | (count_q != len_q);
            if (state == CHECK)
                error <= err_pending;
        end
    end

    for (genvar k = 0; k < NPORTS; k++) begin : g_port
        logic [DW-1:0] mem [DEPTH];
        logic [PW-1:0] wr_ptr, rd_ptr;
        logic [PW:0]   cnt;
        logic [TW-1:0] tmo;
        logic [DW-1:0] dout;
        logic          srst;
        logic          vld, rd, wr, flush;

        assign vld     = (cnt != '0);
        assign full[k] = (cnt == (PW+1)'(DEPTH));
        // A flush discards any beat written on the same edge.
        assign flush   = (tmo == TW'(TIMEOUT - 1)) && vld && !read_enb[k];
        assign rd      = read_enb[k] && vld;
        assign wr      = wr_en[k] && !flush;

        assign vld_out[k]            = vld;
        assign soft_rst[k]           = srst;
        assign data_out[k*DW +: DW]  = dout;

        always_ff @(posedge clock) begin
            if (wr)
                mem[wr_ptr] <= data_in;
        end

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                tmo    <= '0;
                dout   <= '0;
                srst   <= 1'b0;
            end else begin
                srst <= flush;
                if (flush) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    cnt    <= '0;
                    tmo    <= '0;
                end else begin
                    if (wr)
                        wr_ptr <= wr_ptr + 1'b1;
                    if (rd) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        dout   <= mem[rd_ptr];
                    end
                    if (wr && !rd)
                        cnt <= cnt + 1'b1;
                    else if (rd && !wr)
                        cnt <= cnt - 1'b1;
                    if (rd || !vld)
                        tmo <= '0;
                    else
                        tmo <= tmo + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_nport.sv
// Directed bench for router_nport (3 ports, so header address 3 exercises the drop path).
module tb_router_nport;

    logic        clock     = 1'b0;
    logic        resetn    = 1'b1;
    logic        pkt_valid = 1'b0;
    logic [7:0]  data_in   = 8'h00;
    logic [2:0]  read_enb  = 3'b000;
    logic [23:0] data_out;
    logic [2:0]  vld_out;
    logic        busy;
    logic        error;
    logic        drop;
    logic [2:0]  soft_rst;

    int checks = 0;
    int errors = 0;

    logic [7:0] got[$];
    logic       mon_en   = 1'b0;
    logic       mon_pend = 1'b0;

    always #5 clock = ~clock;

    router_nport #(.DW(8), .NPORTS(3), .DEPTH(16), .TIMEOUT(30)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .read_enb(read_enb), .data_out(data_out), .vld_out(vld_out), .busy(busy),
        .error(error), .drop(drop), .soft_rst(soft_rst)
    );

    // Collects port-1 read data: a read at a posedge shows up on data_out by the next negedge.
    always @(negedge clock) begin
        if (mon_pend)
            got.push_back(data_out[15:8]);
        mon_pend <= mon_en && read_enb[1] && vld_out[1];
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=hang required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic v, input logic [7:0] d);
        int guard;
        guard     = 0;
        pkt_valid = v;
        data_in   = d;
        #1;
        while (busy === 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100)
            check("busy_stuck", {31'd0, busy}, 32'd0);
        tick();
    endtask

    task automatic read_byte(input int port, input logic [7:0] exp, input string tag);
        read_enb[port] = 1'b1;
        tick();
        check(tag, {24'd0, data_out[port*8 +: 8]}, {24'd0, exp});
    endtask

    initial begin
        logic [7:0] pkt1 [8];
        logic [7:0] exp5 [22];
        int         guard;

        pkt1 = '{8'h1A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h6D};

        // Reset
        #1 resetn = 1'b0;
        #2;
        check("rst_data_out", {8'd0, data_out}, 32'd0);
        check("rst_vld_out", {29'd0, vld_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_drop", {31'd0, drop}, 32'd0);
        check("rst_soft_rst", {29'd0, soft_rst}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        tick();

        // Port 2, len 6, good parity
        send_beat(1'b1, 8'h1A);
        check("p2_vld_after_hdr", {29'd0, vld_out}, 32'b100);
        for (int i = 1; i < 7; i++)
            send_beat(1'b1, pkt1[i]);
        send_beat(1'b0, 8'h6D);
        check("p2_busy_in_check", {31'd0, busy}, 32'd1);
        tick();
        check("p2_busy_after_check", {31'd0, busy}, 32'd0);
        check("p2_error_good", {31'd0, error}, 32'd0);
        for (int i = 0; i < 8; i++)
            read_byte(2, pkt1[i], $sformatf("p2_read_%0d", i));
        check("p2_vld_drained", {29'd0, vld_out}, 32'd0);
        read_byte(2, 8'h6D, "p2_read_empty_holds");
        read_enb = 3'b000;

        // Same packet with a corrupted parity byte
        for (int i = 0; i < 7; i++)
            send_beat(1'b1, pkt1[i]);
        send_beat(1'b0, 8'h6C);
        tick();
        check("parity_error_set", {31'd0, error}, 32'd1);
        for (int i = 0; i < 7; i++)
            read_byte(2, pkt1[i], $sformatf("bad_read_%0d", i));
        read_byte(2, 8'h6C, "bad_read_parity");
        read_enb = 3'b000;

        // Header len 5 with 7 payload bytes; valid header clears the old error
        send_beat(1'b1, 8'h16);
        check("error_clear_on_hdr", {31'd0, error}, 32'd0);
        for (int i = 1; i <= 7; i++)
            send_beat(1'b1, 8'(i));
        send_beat(1'b0, 8'h16);
        tick();
        check("len_error_set", {31'd0, error}, 32'd1);
        for (int i = 0; i < 9; i++)
            read_byte(2, (i == 0 || i == 8) ? 8'h16 : 8'(i), $sformatf("len_read_%0d", i));
        read_enb = 3'b000;
        check("len_vld_drained", {29'd0, vld_out}, 32'd0);

        // Address 3 on a 3-port router is dropped
        send_beat(1'b1, 8'h1B);
        check("drop_pulse", {31'd0, drop}, 32'd1);
        check("drop_no_vld", {29'd0, vld_out}, 32'd0);
        send_beat(1'b1, 8'hAA);
        check("drop_one_cycle", {31'd0, drop}, 32'd0);
        send_beat(1'b1, 8'hBB);
        send_beat(1'b0, 8'hCC);
        check("drop_still_no_vld", {29'd0, vld_out}, 32'd0);
        check("drop_error_unchanged", {31'd0, error}, 32'd1);
        send_beat(1'b1, 8'h04);
        check("after_drop_vld_p0", {29'd0, vld_out}, 32'b001);
        check("after_drop_error_clr", {31'd0, error}, 32'd0);
        send_beat(1'b1, 8'hA5);
        send_beat(1'b0, 8'hA1);
        tick();
        check("after_drop_error", {31'd0, error}, 32'd0);
        read_byte(0, 8'h04, "p0_read_hdr");
        read_byte(0, 8'hA5, "p0_read_pay");
        read_byte(0, 8'hA1, "p0_read_par");
        read_enb = 3'b000;

        // 20-byte packet to port 1 fills the 16-entry FIFO
        exp5[0]  = 8'h51;
        for (int i = 1; i <= 20; i++)
            exp5[i] = 8'(i);
        exp5[21] = 8'h45;
        mon_en = 1'b1;
        for (int i = 0; i < 16; i++)
            send_beat(1'b1, exp5[i]);
        pkt_valid = 1'b1;
        data_in   = exp5[16];
        #1;
        check("full_busy", {31'd0, busy}, 32'd1);
        read_enb = 3'b010;
        for (int i = 16; i < 21; i++)
            send_beat(1'b1, exp5[i]);
        send_beat(1'b0, exp5[21]);
        tick();
        check("full_pkt_error", {31'd0, error}, 32'd0);
        guard = 0;
        while (vld_out[1] === 1'b1 && guard < 60) begin
            tick();
            guard++;
        end
        check("full_drain_done", {31'd0, vld_out[1]}, 32'd0);
        @(negedge clock);
        #1;
        mon_en   = 1'b0;
        read_enb = 3'b000;
        check("full_read_count", got.size(), 32'd22);
        for (int i = 0; i < 22; i++)
            if (i < got.size())
                check($sformatf("full_read_%0d", i), {24'd0, got[i]}, {24'd0, exp5[i]});

        // Port 0 left unread for TIMEOUT cycles is flushed
        send_beat(1'b1, 8'h04);
        send_beat(1'b1, 8'hA5);
        send_beat(1'b0, 8'hA1);
        repeat (27) tick();
        check("tmo_not_yet_vld", {29'd0, vld_out}, 32'b001);
        check("tmo_not_yet_srst", {29'd0, soft_rst}, 32'd0);
        tick();
        check("tmo_soft_rst", {29'd0, soft_rst}, 32'b001);
        check("tmo_vld_cleared", {29'd0, vld_out}, 32'd0);
        tick();
        check("tmo_soft_rst_pulse", {29'd0, soft_rst}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
